rename_ctrl: RTL and testbench

- Sequences the register rename map table for the out-of-order core.
- Owns the physical-register free list and accepts rename requests from decode via a valid/ready handshake.
- For each request it pops a free physical register and drives the table's reg_to_map/new_mapping/remap inputs.
- Returns physical registers to the free list at commit; on flush it asserts the table's overwrite and rewinds the speculative free-list head.

---
 rtl/rename_ctrl.sv | 125 ++++++++++++
 tb/tb_rename_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rename_ctrl.sv
// Rename sequencer: owns the physical-register free list, feeds the rename map table,
// and rewinds speculative allocation on flush.
module rename_ctrl #(
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned NUM_AREGS = 32,
  parameter int unsigned FL_DEPTH  = NUM_PREGS - NUM_AREGS,
  parameter              tag       = "RenameCtrl"
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             req_valid,
  input  logic [$clog2(NUM_AREGS)-1:0]     req_areg,
  output logic                             req_ready,
  output logic                             resp_valid,
  output logic [$clog2(NUM_PREGS)-1:0]     resp_preg,
  output logic [$clog2(NUM_AREGS)-1:0]     reg_to_map,
  output logic [$clog2(NUM_PREGS)-1:0]     new_mapping,
  output logic                             remap,
  output logic                             overwrite,
  input  logic [$clog2(NUM_PREGS)-1:0]     returned_mapping,
  input  logic                             return_map,
  output logic [$clog2(NUM_PREGS)-1:0]     old_preg,
  output logic                             old_valid,
  input  logic                             commit_alloc,
  input  logic                             commit_free,
  input  logic [$clog2(NUM_PREGS)-1:0]     commit_preg,
  input  logic                             flush,
  output logic [$clog2(FL_DEPTH):0]        fl_count,
  output logic                             err
);

  localparam int unsigned PW   = $clog2(NUM_PREGS);
  localparam int unsigned IW   = $clog2(FL_DEPTH);
  localparam int unsigned PTRW = IW + 1;

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [PTRW-1:0]   head, tail, retire_head;
  logic [PTRW-1:0]   head_nxt, tail_nxt, retire_nxt;
  logic [PW-1:0]     fl [FL_DEPTH];
  logic              accept, pop, push, retire, err_set, full, take_old;
  logic [PW-1:0]     pop_tag;

  // Debug prefix has no hardware meaning; keep it referenced.
  logic unused_tag;
  assign unused_tag = ^tag;

  assign fl_count  = tail - head;
  assign full      = (fl_count == PTRW'(FL_DEPTH));
  assign req_ready = (state == RUN) && !stall && ((fl_count != '0) || (req_areg == '0));
  assign pop_tag   = fl[head[IW-1:0]];

  // Next-state, pointer updates and error detection.
  always_comb begin
    state_nxt  = state;
    head_nxt   = head;
    tail_nxt   = tail;
    retire_nxt = retire_head;
    accept     = req_valid && req_ready && !flush;
    pop        = accept && (req_areg != '0);
    push       = commit_free && !full;
    retire     = commit_alloc && (retire_head != head);
    err_set    = (commit_free && full) || (commit_alloc && (retire_head == head));
    take_old   = 1'b0;
    if (retire) retire_nxt = retire_head + PTRW'(1);
    if (push)   tail_nxt   = tail + PTRW'(1);
    if (pop)    head_nxt   = head + PTRW'(1);
    unique case (state)
      RUN: begin
        if (flush) state_nxt = FLUSH;
      end
      FLUSH: begin
        head_nxt  = retire_nxt;
        state_nxt = flush ? FLUSH : DRAIN;
      end
      DRAIN: begin
        state_nxt = flush ? FLUSH : RUN;
      end
      default: state_nxt = RUN;
    endcase
    take_old = return_map && (state == RUN) && (state_nxt == RUN);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      state <= RUN;
    else if (!stall) state <= state_nxt;
  end

  // Pointers, free-list storage and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head        <= '0;
      retire_head <= '0;
      tail        <= PTRW'(FL_DEPTH);
      for (int i = 0; i < int'(FL_DEPTH); i++) fl[i] <= PW'(NUM_AREGS + i);
      resp_valid  <= 1'b0;
      resp_preg   <= '0;
      reg_to_map  <= '0;
      new_mapping <= '0;
      remap       <= 1'b0;
      overwrite   <= 1'b0;
      old_valid   <= 1'b0;
      old_preg    <= '0;
      err         <= 1'b0;
    end else if (!stall) begin
      head        <= head_nxt;
      tail        <= tail_nxt;
      retire_head <= retire_nxt;
      if (push) fl[tail[IW-1:0]] <= commit_preg;
      resp_valid  <= accept;
      remap       <= pop;
      resp_preg   <= pop ? pop_tag : '0;
      new_mapping <= pop ? pop_tag : '0;
      reg_to_map  <= pop ? req_areg : '0;
      overwrite   <= (state_nxt == FLUSH);
      old_valid   <= take_old;
      old_preg    <= take_old ? returned_mapping : '0;
      err         <= err | err_set;
    end
  end

endmodule

// File: tb/tb_rename_ctrl.sv
// Directed bench for rename_ctrl: allocation order, empty/full limits, flush rewind, stall, reset.
module tb_rename_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall, req_valid, req_ready, resp_valid, remap, overwrite;
  logic [4:0] req_areg, reg_to_map;
  logic [5:0] resp_preg, new_mapping, returned_mapping, old_preg, commit_preg, fl_count;
  logic       return_map, old_valid, commit_alloc, commit_free, flush, err;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rename_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall),
    .req_valid(req_valid), .req_areg(req_areg), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_preg(resp_preg),
    .reg_to_map(reg_to_map), .new_mapping(new_mapping), .remap(remap), .overwrite(overwrite),
    .returned_mapping(returned_mapping), .return_map(return_map),
    .old_preg(old_preg), .old_valid(old_valid),
    .commit_alloc(commit_alloc), .commit_free(commit_free), .commit_preg(commit_preg),
    .flush(flush), .fl_count(fl_count), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic idle();
    stall = 1'b0; req_valid = 1'b0; req_areg = '0;
    returned_mapping = '0; return_map = 1'b0;
    commit_alloc = 1'b0; commit_free = 1'b0; commit_preg = '0; flush = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #2;

    // Reset state and first rename with table return.
    do_reset();
    chk("rst_fl_count", fl_count, 32);
    chk("rst_err", err, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_overwrite", overwrite, 0);
    chk("rst_old_valid", old_valid, 0);
    req_valid = 1'b1; req_areg = 5'd5; #1;
    chk("first_ready", req_ready, 1);
    cyc();
    chk("first_resp_valid", resp_valid, 1);
    chk("first_resp_preg", resp_preg, 32);
    chk("first_remap", remap, 1);
    chk("first_reg_to_map", reg_to_map, 5);
    chk("first_new_mapping", new_mapping, 32);
    req_valid = 1'b0; return_map = 1'b1; returned_mapping = 6'd5;
    cyc();
    chk("first_old_valid", old_valid, 1);
    chk("first_old_preg", old_preg, 5);
    chk("first_idle_resp", resp_valid, 0);
    chk("first_idle_remap", remap, 0);
    chk("first_fl_count", fl_count, 31);
    return_map = 1'b0;

    // Drain the whole free list back to back.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      req_valid = 1'b1;
      req_areg  = (i == 31) ? 5'd1 : 5'(i + 1);
      cyc();
      chk("seq_resp_preg", resp_preg, 32 + i);
    end
    chk("empty_fl_count", fl_count, 0);
    req_areg = 5'd3; #1;
    chk("empty_ready_areg3", req_ready, 0);
    cyc();
    chk("empty_no_resp", resp_valid, 0);
    req_areg = 5'd0; #1;
    chk("empty_ready_areg0", req_ready, 1);
    cyc();
    chk("areg0_resp_valid", resp_valid, 1);
    chk("areg0_resp_preg", resp_preg, 0);
    chk("areg0_remap", remap, 0);
    chk("areg0_reg_to_map", reg_to_map, 0);

    // Free into an empty list is not bypassed to a same-cycle request.
    commit_free = 1'b1; commit_preg = 6'd40; req_areg = 5'd7; #1;
    chk("free_nobypass_ready", req_ready, 0);
    cyc();
    commit_free = 1'b0; #1;
    chk("free_next_ready", req_ready, 1);
    chk("free_fl_count", fl_count, 1);
    chk("free_no_resp", resp_valid, 0);
    cyc();
    chk("free_resp_valid", resp_valid, 1);
    chk("free_resp_preg", resp_preg, 40);
    chk("free_reg_to_map", reg_to_map, 7);
    req_valid = 1'b0;

    // Allocate four, retire two, flush: head rewinds by two.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_areg = 5'(i + 1);
      cyc();
      chk("fl4_resp_preg", resp_preg, 32 + i);
    end
    req_valid = 1'b0; commit_alloc = 1'b1;
    cyc(); cyc();
    commit_alloc = 1'b0;
    chk("fl4_pre_count", fl_count, 28);
    flush = 1'b1; #1;
    chk("fl4_ready_run", req_ready, 1);
    cyc();
    flush = 1'b0; req_valid = 1'b1; req_areg = 5'd9; #1;
    chk("fl4_overwrite", overwrite, 1);
    chk("fl4_remap", remap, 0);
    chk("fl4_ready_flush", req_ready, 0);
    cyc();
    chk("fl4_overwrite_drop", overwrite, 0);
    chk("fl4_ready_drain", req_ready, 0);
    chk("fl4_rewound_count", fl_count, 30);
    chk("fl4_drain_resp", resp_valid, 0);
    cyc();
    chk("fl4_ready_back", req_ready, 1);
    chk("fl4_run_resp", resp_valid, 0);
    cyc();
    chk("fl4_next_valid", resp_valid, 1);
    chk("fl4_next_preg", resp_preg, 34);
    chk("fl4_next_mapping", new_mapping, 34);
    req_valid = 1'b0;

    // Flush coincident with a request and commits in the flush and FLUSH cycles.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_areg = 5'(i + 1);
      cyc();
    end
    req_areg = 5'd6; commit_alloc = 1'b1; flush = 1'b1;
    return_map = 1'b1; returned_mapping = 6'd3; #1;
    chk("co_ready", req_ready, 1);
    cyc();
    chk("co_no_resp", resp_valid, 0);
    chk("co_no_remap", remap, 0);
    chk("co_overwrite", overwrite, 1);
    chk("co_old_forced", old_valid, 0);
    flush = 1'b0; req_valid = 1'b0; return_map = 1'b0;
    cyc();
    commit_alloc = 1'b0;
    chk("co_count", fl_count, 30);
    chk("co_old_drain", old_valid, 0);
    cyc();
    req_valid = 1'b1; req_areg = 5'd6;
    cyc();
    chk("co_next_preg", resp_preg, 34);
    req_valid = 1'b0;

    // Retire-head underflow and free-list overflow set sticky err.
    do_reset();
    commit_alloc = 1'b1;
    cyc();
    commit_alloc = 1'b0;
    chk("underflow_err", err, 1);
    do_reset();
    chk("err_cleared", err, 0);
    commit_free = 1'b1; commit_preg = 6'd50;
    cyc();
    commit_free = 1'b0;
    chk("overflow_err", err, 1);
    chk("overflow_count", fl_count, 32);
    cyc();
    chk("err_sticky", err, 1);

    // Stall freezes everything, including an uncaptured commit.
    req_valid = 1'b1; req_areg = 5'd5;
    cyc();
    chk("stall_pre_preg", resp_preg, 32);
    stall = 1'b1; req_areg = 5'd6; commit_free = 1'b1; commit_preg = 6'd45; #1;
    chk("stall_ready", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_resp_valid", resp_valid, 1);
      chk("stall_resp_preg", resp_preg, 32);
      chk("stall_reg_to_map", reg_to_map, 5);
      chk("stall_fl_count", fl_count, 31);
    end
    stall = 1'b0; commit_free = 1'b0; #1;
    chk("resume_ready", req_ready, 1);
    cyc();
    chk("resume_preg", resp_preg, 33);
    chk("resume_reg_to_map", reg_to_map, 6);
    chk("resume_count", fl_count, 30);
    chk("resume_err", err, 1);
    req_valid = 1'b0;

    // Asynchronous reset mid-operation.
    #2 reset = 1'b0;
    #1;
    chk("async_rst_err", err, 0);
    chk("async_rst_count", fl_count, 32);
    chk("async_rst_resp", resp_valid, 0);
    @(negedge clk) reset = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
